// File: rtl/qea_seq_pkg.sv
// qea_seq_pkg: shared types and helpers for the QEA run sequencer.
//   seq_state_e  - sequencer FSM states
//   word_count   - STATE RAM words for a qubit count
//   cmd_legal    - job command legality check
package qea_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_CTX,
    LOAD_ST,
    START,
    RUN,
    RD_ADDR,
    RD_WAIT,
    RD_OUT
  } seq_state_e;

  // Wide enough to count RD_LATENCY cycles (1..4).
  localparam int LAT_W = 3;

  // Each STATE RAM word holds 2^pe_w amplitudes, so a job with qbit qubits
  // needs 2^(qbit-pe_w) words, with a floor of one word.
  function automatic int word_count(input int qbit, input int pe_w);
    return (qbit <= pe_w) ? 1 : (1 << (qbit - pe_w));
  endfunction

  function automatic logic cmd_legal(input int qbit, input int ins,
                                     input int st_aw, input int pe_w,
                                     input int ctx_aw);
    return (qbit <= st_aw + pe_w) &&
           (longint'(ins) <= (longint'(1) << ctx_aw));
  endfunction

endpackage

// File: rtl/qea_seq_out_slice.sv
// qea_seq_out_slice: single-entry output register for the readback stream.
//   in_valid/in_data/in_last - load strobe; only asserted while empty
//   out_valid/out_ready      - downstream handshake
//   out_data/out_last        - held stable until the handshake
module qea_seq_out_slice #(
  parameter int W = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last
);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (in_valid) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
      out_last  <= in_last;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/qea_run_sequencer.sv
// qea_run_sequencer: runs one QEA job end to end.
//   cmd  - job command (qbit count, CTX word count)
//   ctx  - gate-context stream, written to CTX RAM at 0..ins_num-1
//   st   - initial state stream, written to STATE RAM at 0..W-1
//   qea  - QEA control, CTX and STATE RAM ports, complete input
//   out  - readback stream with last flag and backpressure
//   busy/done/error status, exec_cycles START..complete count
// Optional: define QEA_SEQ_CYCLE_COUNT_EN to build the exec cycle counter;
// otherwise o_exec_cycles is tied to 0.
module qea_run_sequencer
  import qea_seq_pkg::*;
#(
  parameter int PE_NUM_WIDTH            = 2,
  parameter int PE_NUM                  = 4,
  parameter int STATE_DATA_WIDTH        = 64,
  parameter int STATE_ADDR_WIDTH        = 16,
  parameter int GATE_CONTEXT_DATA_WIDTH = 64,
  parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
  parameter int MAX_QBIT_WIDTH          = 6,
  parameter int RD_LATENCY              = 1,
  parameter int TIMEOUT_CYCLES          = 1048576
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               i_cmd_valid,
  output logic                               o_cmd_ready,
  input  logic [MAX_QBIT_WIDTH-1:0]          i_cmd_qbit_num,
  input  logic [GATE_CONTEXT_ADDR_WIDTH:0]   i_cmd_ins_num,
  input  logic                               i_ctx_valid,
  output logic                               o_ctx_ready,
  input  logic [GATE_CONTEXT_DATA_WIDTH-1:0] i_ctx_data,
  input  logic                               i_st_valid,
  output logic                               o_st_ready,
  input  logic [PE_NUM*STATE_DATA_WIDTH-1:0] i_st_data,
  output logic                               o_out_valid,
  input  logic                               i_out_ready,
  output logic [PE_NUM*STATE_DATA_WIDTH-1:0] o_out_data,
  output logic                               o_out_last,
  output logic                               o_busy,
  output logic                               o_done,
  output logic                               o_error,
  output logic [31:0]                        o_exec_cycles,
  output logic                               o_qea_start,
  output logic [MAX_QBIT_WIDTH-1:0]          o_qea_qbit_num,
  output logic                               o_qea_ctx_en,
  output logic                               o_qea_ctx_wea,
  output logic [GATE_CONTEXT_ADDR_WIDTH-1:0] o_qea_ctx_addr,
  output logic [GATE_CONTEXT_DATA_WIDTH-1:0] o_qea_ctx_data,
  output logic                               o_qea_state_ena,
  output logic                               o_qea_state_wea,
  output logic [STATE_ADDR_WIDTH-1:0]        o_qea_state_addra,
  output logic [PE_NUM*STATE_DATA_WIDTH-1:0] o_qea_state_dina,
  input  logic                               i_qea_complete,
  input  logic [PE_NUM*STATE_DATA_WIDTH-1:0] i_qea_state_dout
);

  localparam int SW     = PE_NUM * STATE_DATA_WIDTH;
  localparam int WCNT_W = STATE_ADDR_WIDTH + 1;
  localparam int IDX_W  = ((GATE_CONTEXT_ADDR_WIDTH > STATE_ADDR_WIDTH) ?
                           GATE_CONTEXT_ADDR_WIDTH : STATE_ADDR_WIDTH) + 1;
  localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);

  seq_state_e state, state_nxt;

  logic [MAX_QBIT_WIDTH-1:0]        qbit;
  logic [GATE_CONTEXT_ADDR_WIDTH:0] ins;
  logic [WCNT_W-1:0]                words;
  // Shared word index: CTX k, then STATE load k, then readback j.
  logic [IDX_W-1:0]                 idx;
  logic [IDX_W-1:0]                 idx_inc;
  logic [TO_W-1:0]                  run_cnt;
  logic [LAT_W-1:0]                 lat_cnt;
  logic                             done_nxt, error_nxt;
  logic                             cmd_ok, ctx_fire, st_fire;
  logic                             ctx_last, st_last;
  logic                             complete_seen, timeout_hit, lat_done, out_fire;

  assign idx_inc  = idx + 1'b1;
  assign cmd_ok   = cmd_legal(int'(i_cmd_qbit_num), int'(i_cmd_ins_num),
                              STATE_ADDR_WIDTH, PE_NUM_WIDTH,
                              GATE_CONTEXT_ADDR_WIDTH);
  assign ctx_fire = (state == LOAD_CTX) && i_ctx_valid;
  assign st_fire  = (state == LOAD_ST) && i_st_valid;
  assign ctx_last = (idx_inc == IDX_W'(ins));
  // Same compare ends the state load and flags the last readback word.
  assign st_last  = (idx_inc == IDX_W'(words));

  // The first RUN cycle may still see a stale complete from a previous
  // job, so complete is only honoured once run_cnt has moved past zero.
  assign complete_seen = (state == RUN) && (run_cnt != '0) && i_qea_complete;
  assign timeout_hit   = (state == RUN) && !complete_seen &&
                         (run_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign lat_done      = (state == RD_WAIT) && (lat_cnt == LAT_W'(RD_LATENCY - 1));
  assign out_fire      = o_out_valid && i_out_ready;

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    error_nxt = 1'b0;
    unique case (state)
      IDLE:
        if (i_cmd_valid) begin
          if (!cmd_ok)                 error_nxt = 1'b1;
          else if (i_cmd_ins_num == '0) state_nxt = LOAD_ST;
          else                         state_nxt = LOAD_CTX;
        end
      LOAD_CTX: if (ctx_fire && ctx_last) state_nxt = LOAD_ST;
      LOAD_ST:  if (st_fire && st_last)   state_nxt = START;
      START:    state_nxt = RUN;
      RUN:
        if (complete_seen) state_nxt = RD_ADDR;
        else if (timeout_hit) begin
          state_nxt = IDLE;
          error_nxt = 1'b1;
        end
      RD_ADDR:  state_nxt = RD_WAIT;
      RD_WAIT:  if (lat_done) state_nxt = RD_OUT;
      RD_OUT:
        if (out_fire) begin
          if (o_out_last) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = RD_ADDR;
          end
        end
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      qbit    <= '0;
      ins     <= '0;
      words   <= '0;
      idx     <= '0;
      run_cnt <= '0;
      lat_cnt <= '0;
      o_done  <= 1'b0;
      o_error <= 1'b0;
    end else begin
      state   <= state_nxt;
      o_done  <= done_nxt;
      o_error <= error_nxt;
      if (state == IDLE && i_cmd_valid && cmd_ok) begin
        qbit  <= i_cmd_qbit_num;
        ins   <= i_cmd_ins_num;
        words <= WCNT_W'(word_count(int'(i_cmd_qbit_num), PE_NUM_WIDTH));
      end
      if (state == IDLE)                   idx <= '0;
      else if (ctx_fire)                   idx <= ctx_last ? '0 : idx_inc;
      else if (st_fire)                    idx <= st_last ? '0 : idx_inc;
      else if (state == RD_OUT && out_fire) idx <= o_out_last ? '0 : idx_inc;
      if (state == START)    run_cnt <= '0;
      else if (state == RUN) run_cnt <= run_cnt + 1'b1;
      if (state == RD_ADDR)      lat_cnt <= '0;
      else if (state == RD_WAIT) lat_cnt <= lat_cnt + 1'b1;
    end
  end

`ifdef QEA_SEQ_CYCLE_COUNT_EN
  // START counts as cycle 1; the cycle that samples complete is not added.
  logic [31:0] exec_cnt;
  always_ff @(posedge clk) begin
    if (rst)                                            exec_cnt <= '0;
    else if (state == START)                            exec_cnt <= 32'd1;
    else if (state == RUN && !complete_seen && exec_cnt != '1) exec_cnt <= exec_cnt + 1'b1;
  end
  assign o_exec_cycles = exec_cnt;
`else
  assign o_exec_cycles = '0;
`endif

  qea_seq_out_slice #(.W(SW)) u_out_slice (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (lat_done),
    .in_data   (i_qea_state_dout),
    .in_last   (st_last),
    .out_valid (o_out_valid),
    .out_ready (i_out_ready),
    .out_data  (o_out_data),
    .out_last  (o_out_last)
  );

  // Ready signals decode state only so the upstream valid never loops back.
  assign o_cmd_ready       = (state == IDLE);
  assign o_ctx_ready       = (state == LOAD_CTX);
  assign o_st_ready        = (state == LOAD_ST);
  assign o_busy            = (state != IDLE);
  assign o_qea_start       = (state == START);
  assign o_qea_qbit_num    = qbit;
  assign o_qea_ctx_en      = ctx_fire;
  assign o_qea_ctx_wea     = ctx_fire;
  assign o_qea_ctx_addr    = ctx_fire ? idx[GATE_CONTEXT_ADDR_WIDTH-1:0] : '0;
  assign o_qea_ctx_data    = ctx_fire ? i_ctx_data : '0;
  assign o_qea_state_ena   = st_fire || (state == RD_ADDR);
  assign o_qea_state_wea   = st_fire;
  assign o_qea_state_addra = (st_fire || state == RD_ADDR) ?
                             idx[STATE_ADDR_WIDTH-1:0] : '0;
  assign o_qea_state_dina  = st_fire ? i_st_data : '0;

endmodule

// File: tb/tb_qea_run_sequencer.sv
// tb_qea_run_sequencer: directed bench for qea_run_sequencer with a mock
// QEA (complete after a set delay, STATE RAM read returns an address pattern).
module tb_qea_run_sequencer;

  localparam int SW = 256;

  logic           clk = 1'b0;
  logic           rst;
  logic           i_cmd_valid;
  logic           o_cmd_ready;
  logic [5:0]     i_cmd_qbit_num;
  logic [16:0]    i_cmd_ins_num;
  logic           i_ctx_valid;
  logic           o_ctx_ready;
  logic [63:0]    i_ctx_data;
  logic           i_st_valid;
  logic           o_st_ready;
  logic [SW-1:0]  i_st_data;
  logic           o_out_valid;
  logic           i_out_ready;
  logic [SW-1:0]  o_out_data;
  logic           o_out_last;
  logic           o_busy, o_done, o_error;
  logic [31:0]    o_exec_cycles;
  logic           o_qea_start;
  logic [5:0]     o_qea_qbit_num;
  logic           o_qea_ctx_en, o_qea_ctx_wea;
  logic [15:0]    o_qea_ctx_addr;
  logic [63:0]    o_qea_ctx_data;
  logic           o_qea_state_ena, o_qea_state_wea;
  logic [15:0]    o_qea_state_addra;
  logic [SW-1:0]  o_qea_state_dina;
  logic           i_qea_complete = 1'b0;
  logic [SW-1:0]  i_qea_state_dout = '0;

  qea_run_sequencer #(
    .RD_LATENCY     (1),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clk(clk), .rst(rst),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_qbit_num(i_cmd_qbit_num), .i_cmd_ins_num(i_cmd_ins_num),
    .i_ctx_valid(i_ctx_valid), .o_ctx_ready(o_ctx_ready), .i_ctx_data(i_ctx_data),
    .i_st_valid(i_st_valid), .o_st_ready(o_st_ready), .i_st_data(i_st_data),
    .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
    .o_out_data(o_out_data), .o_out_last(o_out_last),
    .o_busy(o_busy), .o_done(o_done), .o_error(o_error),
    .o_exec_cycles(o_exec_cycles),
    .o_qea_start(o_qea_start), .o_qea_qbit_num(o_qea_qbit_num),
    .o_qea_ctx_en(o_qea_ctx_en), .o_qea_ctx_wea(o_qea_ctx_wea),
    .o_qea_ctx_addr(o_qea_ctx_addr), .o_qea_ctx_data(o_qea_ctx_data),
    .o_qea_state_ena(o_qea_state_ena), .o_qea_state_wea(o_qea_state_wea),
    .o_qea_state_addra(o_qea_state_addra), .o_qea_state_dina(o_qea_state_dina),
    .i_qea_complete(i_qea_complete), .i_qea_state_dout(i_qea_state_dout)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ctx_pat(input int k);
    return 64'hC700_0000_0000_0000 | 64'(k);
  endfunction
  function automatic logic [SW-1:0] st_pat(input int k);
    return {4{32'h5A5A_0000 | 32'(k), 32'(k)}};
  endfunction
  function automatic logic [SW-1:0] rd_pat(input logic [15:0] a);
    return {4{16'hBEEF, a, 16'hF00D, a}};
  endfunction

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string tag, input logic [SW-1:0] got, input logic [SW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // ---------------- mock QEA ----------------
  int mock_delay = 0;
  always @(posedge clk)
    if (o_qea_state_ena && !o_qea_state_wea) i_qea_state_dout <= rd_pat(o_qea_state_addra);

  always begin
    @(negedge clk);
    if (o_qea_start && mock_delay > 0) begin
      repeat (mock_delay) @(posedge clk);
      #1 i_qea_complete = 1'b1;
      @(posedge clk);
      #1 i_qea_complete = 1'b0;
    end
  end

  // ---------------- monitor (records only) ----------------
  int cyc = 0;
  always @(posedge clk) cyc++;

  int             ctx_addr_q[$], ctx_cyc_q[$], st_addr_q[$], st_cyc_q[$];
  logic [63:0]    ctx_data_q[$];
  logic [SW-1:0]  st_data_q[$], out_data_q[$];
  logic           out_last_q[$];
  int acc_cyc = 0, start_cyc = 0, err_cyc = 0;
  int start_cnt = 0, done_cnt = 0, err_cnt = 0, rd_cnt = 0, wea_bad = 0;
  int stall_chk = 0, stall_bad = 0;
  logic           prev_stall = 1'b0, prev_last = 1'b0;
  logic [SW-1:0]  prev_data = '0;

  always @(negedge clk) begin
    if (i_cmd_valid && o_cmd_ready) acc_cyc = cyc;
    if (o_qea_ctx_en != o_qea_ctx_wea) wea_bad++;
    if (o_qea_ctx_en) begin
      ctx_addr_q.push_back(int'(o_qea_ctx_addr));
      ctx_data_q.push_back(o_qea_ctx_data);
      ctx_cyc_q.push_back(cyc);
    end
    if (o_qea_state_ena && o_qea_state_wea) begin
      st_addr_q.push_back(int'(o_qea_state_addra));
      st_data_q.push_back(o_qea_state_dina);
      st_cyc_q.push_back(cyc);
    end
    if (o_qea_state_ena && !o_qea_state_wea) rd_cnt++;
    if (o_qea_start) begin start_cnt++; start_cyc = cyc; end
    if (o_done) done_cnt++;
    if (o_error) begin err_cnt++; err_cyc = cyc; end
    if (prev_stall) begin
      stall_chk++;
      if (!(o_out_valid && o_out_data == prev_data && o_out_last == prev_last)) stall_bad++;
    end
    if (o_out_valid && i_out_ready) begin
      out_data_q.push_back(o_out_data);
      out_last_q.push_back(o_out_last);
    end
    prev_stall = o_out_valid && !i_out_ready;
    prev_data  = o_out_data;
    prev_last  = o_out_last;
  end

  // ---------------- drivers ----------------
  task automatic send_cmd(input int q, input int n);
    i_cmd_valid = 1'b1;
    i_cmd_qbit_num = 6'(q);
    i_cmd_ins_num = 17'(n);
    @(negedge clk);
    chk("cmd_ready", o_cmd_ready, 1);
    @(posedge clk); #1;
    i_cmd_valid = 1'b0;
  endtask

  task automatic feed_ctx(input int n);
    int k = 0, guard = 0;
    logic hs;
    while (k < n && guard < 4 * n + 20) begin
      i_ctx_valid = 1'b1;
      i_ctx_data = ctx_pat(k);
      @(negedge clk); hs = o_ctx_ready;
      @(posedge clk); #1;
      if (hs) k++;
      guard++;
    end
    i_ctx_valid = 1'b0;
    chk("ctx_feed", k, n);
  endtask

  task automatic feed_st(input int n);
    int k = 0, guard = 0;
    logic hs;
    while (k < n && guard < 4 * n + 20) begin
      i_st_valid = 1'b1;
      i_st_data = st_pat(k);
      @(negedge clk); hs = o_st_ready;
      @(posedge clk); #1;
      if (hs) k++;
      guard++;
    end
    i_st_valid = 1'b0;
    chk("st_feed", k, n);
  endtask

  task automatic wait_end(input string tag, input int budget, input bit toggle);
    int t = 0;
    int snap = done_cnt + err_cnt;
    while (done_cnt + err_cnt == snap && t < budget) begin
      @(posedge clk); #1;
      if (toggle) i_out_ready = ~i_out_ready;
      t++;
    end
    i_out_ready = 1'b1;
    chk(tag, (t < budget), 1);
  endtask

  task automatic check_st(input string tag, input int s0, input int n);
    int bad = 0;
    chk({tag, "_st_cnt"}, st_addr_q.size() - s0, n);
    for (int k = 0; k < n; k++)
      if (s0 + k >= st_addr_q.size() || st_addr_q[s0+k] != k || st_data_q[s0+k] != st_pat(k)) bad++;
    chk({tag, "_st_words"}, bad, 0);
  endtask

  task automatic check_out(input string tag, input int o0, input int n);
    int bad = 0;
    chk({tag, "_out_cnt"}, out_data_q.size() - o0, n);
    for (int k = 0; k < n; k++)
      if (o0 + k >= out_data_q.size() || out_data_q[o0+k] != rd_pat(16'(k)) ||
          out_last_q[o0+k] != (k == n - 1)) bad++;
    chk({tag, "_out_words"}, bad, 0);
  endtask

  int c0, s0, o0, d0, e0, t0, r0, k0;

  task automatic snap();
    c0 = ctx_addr_q.size(); s0 = st_addr_q.size(); o0 = out_data_q.size();
    d0 = done_cnt; e0 = err_cnt; t0 = start_cnt; r0 = rd_cnt; k0 = stall_chk;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    rst = 1'b1; i_cmd_valid = 1'b0; i_cmd_qbit_num = '0; i_cmd_ins_num = '0;
    i_ctx_valid = 1'b0; i_ctx_data = '0; i_st_valid = 1'b0; i_st_data = '0;
    i_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", o_cmd_ready, 1);
    chk("rst_busy", o_busy, 0);
    chk("rst_done_err", {o_done, o_error}, 0);
    chk("rst_qbit", o_qea_qbit_num, 0);
    chk("rst_ram_en", {o_qea_ctx_en, o_qea_state_ena, o_qea_start}, 0);
    chk("rst_out_valid", o_out_valid, 0);
    chk("rst_exec", o_exec_cycles, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Job A: qbit=4 (W=4), 115 ramp CTX words, complete 37 cycles after start.
    snap(); mock_delay = 37;
    send_cmd(4, 115);
    feed_ctx(115);
    feed_st(4);
    wait_end("a_end", 400, 1'b0);
    chk("a_ctx_cnt", ctx_addr_q.size() - c0, 115);
    bad = 0;
    for (int k = 0; k < 115; k++)
      if (c0 + k >= ctx_addr_q.size() || ctx_addr_q[c0+k] != k || ctx_data_q[c0+k] != ctx_pat(k)) bad++;
    chk("a_ctx_words", bad, 0);
    chk("a_ctx_first_lat", ctx_cyc_q[c0] - acc_cyc, 1);
    chk("a_ctx_burst", ctx_cyc_q[c0+114] - ctx_cyc_q[c0], 114);
    chk("a_wea", wea_bad, 0);
    check_st("a", s0, 4);
    chk("a_starts", start_cnt - t0, 1);
    check_out("a", o0, 4);
    chk("a_done", done_cnt - d0, 1);
    chk("a_err", err_cnt - e0, 0);
    chk("a_qbit", o_qea_qbit_num, 4);
`ifdef QEA_SEQ_CYCLE_COUNT_EN
    chk("a_exec", o_exec_cycles, 37);
`else
    chk("a_exec", o_exec_cycles, 0);
`endif
    @(negedge clk);
    chk("a_idle", {o_busy, o_cmd_ready}, 2'b01);
    @(posedge clk); #1;

    // Job B: qbit=5 (W=8), readback with ready toggling every cycle.
    snap(); mock_delay = 10;
    send_cmd(5, 3);
    feed_ctx(3);
    feed_st(8);
    wait_end("b_end", 600, 1'b1);
    check_st("b", s0, 8);
    check_out("b", o0, 8);
    chk("b_stalls_seen", (stall_chk - k0) > 0, 1);
    chk("b_stall_stable", stall_bad, 0);
    chk("b_done", done_cnt - d0, 1);
    @(posedge clk); #1;

    // Job C: qbit=2 (W=1), ins=0 skips CTX load.
    snap(); mock_delay = 5;
    send_cmd(2, 0);
    feed_st(1);
    wait_end("c_end", 200, 1'b0);
    chk("c_no_ctx", ctx_addr_q.size() - c0, 0);
    chk("c_st_lat", st_cyc_q[s0] - acc_cyc, 1);
    check_st("c", s0, 1);
    check_out("c", o0, 1);
    chk("c_done", done_cnt - d0, 1);
    @(posedge clk); #1;

    // Job D: complete only in the first RUN cycle (ignored) -> timeout.
    snap(); mock_delay = 1;
    send_cmd(3, 2);
    feed_ctx(2);
    feed_st(2);
    wait_end("d_end", 300, 1'b0);
    chk("d_err", err_cnt - e0, 1);
    chk("d_err_cycle", err_cyc - start_cyc, 65);
    chk("d_no_done", done_cnt - d0, 0);
    chk("d_no_reads", rd_cnt - r0, 0);
    chk("d_no_out", out_data_q.size() - o0, 0);
    @(negedge clk);
    chk("d_idle", {o_busy, o_cmd_ready, o_error}, 3'b010);
    @(posedge clk); #1;

    // Illegal commands: qbit=19 and ins=65537.
    snap(); mock_delay = 0;
    send_cmd(19, 4);
    repeat (4) @(posedge clk); #1;
    chk("e_err", err_cnt - e0, 1);
    chk("e_err_lat", err_cyc - acc_cyc, 1);
    chk("e_no_writes", (ctx_addr_q.size() - c0) + (st_addr_q.size() - s0) + (start_cnt - t0), 0);
    chk("e_idle", {o_busy, o_cmd_ready}, 2'b01);
    send_cmd(4, 65537);
    repeat (4) @(posedge clk); #1;
    chk("e_ins_err", err_cnt - e0, 2);
    chk("e_ins_no_writes", (ctx_addr_q.size() - c0) + (st_addr_q.size() - s0), 0);

    // Reset in the middle of LOAD_ST.
    snap();
    send_cmd(6, 0);
    for (int k = 0; k < 3; k++) begin
      i_st_valid = 1'b1; i_st_data = st_pat(k);
      @(posedge clk); #1;
    end
    i_st_data = st_pat(3);
    rst = 1'b1;
    @(negedge clk);
    chk("f_pre_rst_ena", o_qea_state_ena, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("f_ena_wea", {o_qea_state_ena, o_qea_state_wea}, 0);
    chk("f_busy", o_busy, 0);
    chk("f_cmd_ready", o_cmd_ready, 1);
    chk("f_st_ready", o_st_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0; i_st_valid = 1'b0;
    repeat (4) @(posedge clk); #1;
    chk("f_no_pulse", (done_cnt - d0) + (err_cnt - e0) + (start_cnt - t0), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
